joy_db9md_multi: RTL and testbench



---
 rtl/joy_db9md_multi.sv | 141 ++++++++++++++
 tb/tb_joy_db9md_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db9md_multi.sv
// Megadrive/SMS DB9 reader for NPORTS pads behind a splitter, with SMS/3-button/6-button detection per port.
// Outputs commit atomically once per frame with a frame_done pulse; no backpressure, the pin scan is free-running.
module joy_db9md_multi #(
  parameter int NPORTS    = 2,
  parameter int TICK_DIV  = 256,
  parameter int GAP_SLOTS = 16,
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            joy_in,
  output logic                  joy_mdsel,
  output logic [PW-1:0]         joy_port,
  output logic [12*NPORTS-1:0]  joystick,
  output logic [NPORTS-1:0]     pad_md,
  output logic [NPORTS-1:0]     pad_6btn,
  output logic                  frame_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(TICK_DIV - 2);
  localparam logic [PW-1:0] PORT_LAST = PW'(NPORTS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_SLOTS - 1);

  localparam logic [3:0] P0   = 4'd0;
  localparam logic [3:0] P1   = 4'd1;
  localparam logic [3:0] P3   = 4'd3;
  localparam logic [3:0] P4   = 4'd4;
  localparam logic [3:0] PGAP = 4'd8;

  logic [5:0]             joy_m;
  logic [5:0]             joy_s;
  logic [CW-1:0]          count;
  logic [3:0]             phase;
  logic [PW-1:0]          port;
  logic [GW-1:0]          gap;
  logic [12*NPORTS-1:0]   shadow;
  logic [NPORTS-1:0]      md_s;
  logic [NPORTS-1:0]      six_s;

  logic                   tick;
  logic                   last_slot;
  logic [3:0]             phase_nx;
  logic [PW-1:0]          port_nx;
  logic [GW-1:0]          gap_nx;

  assign joy_port = port;

  always_comb begin
    tick      = (count == CNT_LAST);
    last_slot = (phase == PGAP) && (gap == GAP_LAST);
    phase_nx  = phase;
    port_nx   = port;
    gap_nx    = gap;
    if (phase == PGAP) begin
      if (gap == GAP_LAST) begin
        phase_nx = P0;
        gap_nx   = '0;
      end else begin
        gap_nx = gap + GW'(1);
      end
    end else if (port == PORT_LAST) begin
      port_nx  = '0;
      phase_nx = phase + 4'd1;
    end else begin
      port_nx = port + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      joy_m <= 6'h3F;
      joy_s <= 6'h3F;
    end else begin
      joy_m <= joy_in;
      joy_s <= joy_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      phase      <= P0;
      port       <= '0;
      gap        <= '0;
      joy_mdsel  <= 1'b1;
      shadow     <= '0;
      md_s       <= '0;
      six_s      <= '0;
      joystick   <= '0;
      pad_md     <= '0;
      pad_6btn   <= '0;
      frame_done <= 1'b0;
    end else begin
      count      <= tick ? '0 : count + CW'(1);
      // Raised one cycle early so the pulse coincides with the commit edge.
      frame_done <= last_slot && (count == CNT_PRE);
      if (tick) begin
        phase     <= phase_nx;
        port      <= port_nx;
        gap       <= gap_nx;
        // Odd phases drive select low; the gap (phase 8) keeps it high.
        joy_mdsel <= ~phase_nx[0];
        case (phase)
          P0: begin
            shadow[12*port +: 6] <= ~joy_s;
            md_s[port]           <= 1'b0;
            six_s[port]          <= 1'b0;
          end
          P1: begin
            if (joy_s[1:0] == 2'b00) begin
              md_s[port]               <= 1'b1;
              shadow[12*port+6 +: 2]   <= ~joy_s[5:4];
            end else begin
              shadow[12*port+6 +: 2]   <= 2'b00;
            end
          end
          P3: begin
            if (md_s[port] && (joy_s[3:0] == 4'b0000))
              six_s[port] <= 1'b1;
          end
          P4: begin
            shadow[12*port+8 +: 4] <= six_s[port] ? ~joy_s[3:0] : 4'b0000;
          end
          PGAP: begin
            if (gap == GAP_LAST) begin
              joystick <= shadow;
              pad_md   <= md_s;
              pad_6btn <= six_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_db9md_multi.sv
// Bench for joy_db9md_multi: two builds (2 ports and 4 ports) fed by behavioural pad models on a shared select line.
module tb_joy_db9md_multi;

  localparam int TD     = 4;
  localparam int GS     = 2;
  localparam int NA     = 2;
  localparam int NB     = 4;
  localparam int FLEN_A = (8*NA + GS) * TD;
  localparam int NONE = 0, SMS = 1, MD3 = 2, MD6 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  joy_a, joy_b;
  logic        sel_a, sel_b;
  logic [0:0]  port_a;
  logic [1:0]  port_b;
  logic [23:0] js_a;
  logic [47:0] js_b;
  logic [1:0]  md_a, six_a;
  logic [3:0]  md_b, six_b;
  logic        fd_a, fd_b;

  int          checks = 0;
  int          failures = 0;
  int          ta[4];
  int          tb4[4];
  logic [11:0] ba[4];
  logic [11:0] bb[4];

  always #5 clk = ~clk;

  joy_db9md_multi #(.NPORTS(NA), .TICK_DIV(TD), .GAP_SLOTS(GS)) dut_a (
    .clk(clk), .reset(reset), .joy_in(joy_a), .joy_mdsel(sel_a), .joy_port(port_a),
    .joystick(js_a), .pad_md(md_a), .pad_6btn(six_a), .frame_done(fd_a)
  );

  joy_db9md_multi #(.NPORTS(NB), .TICK_DIV(TD), .GAP_SLOTS(GS)) dut_b (
    .clk(clk), .reset(reset), .joy_in(joy_b), .joy_mdsel(sel_b), .joy_port(port_b),
    .joystick(js_b), .pad_md(md_b), .pad_6btn(six_b), .frame_done(fd_b)
  );

  // Button vector b: 0 R,1 L,2 D,3 U,4 B,5 C,6 A,7 S,8 M,9 X,10 Y,11 Z. lows = select-low pulses since pad reset.
  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b, input logic sel, input int lows);
    logic six_win;
    six_win = (typ == MD6) && (lows == 2 || lows == 3);
    if (typ == NONE) return 6'h3F;
    if (typ == SMS) return ~b[5:0];
    if (sel) begin
      if (six_win) return ~{b[5], b[4], b[11], b[10], b[9], b[8]};
      return ~b[5:0];
    end
    if (six_win) return {~b[7], ~b[6], 4'b0000};
    if (typ == MD6 && lows == 4) return {~b[7], ~b[6], 4'b1111};
    return {~b[7], ~b[6], ~b[3], ~b[2], 2'b00};
  endfunction

  function automatic logic [11:0] exp_slice(input int typ, input logic [11:0] b);
    case (typ)
      SMS:     return {6'b0, b[5:0]};
      MD3:     return {4'b0, b[7:0]};
      MD6:     return b;
      default: return 12'h000;
    endcase
  endfunction

  // Physically impossible combinations (L+R, U+D) are never pressed.
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  int   lows_a = 0, hi_a = 0, lows_b = 0, hi_b = 0;
  logic prev_a = 1'b1, prev_b = 1'b1;

  always @(negedge clk) begin
    if (sel_a === 1'b1) begin
      hi_a++;
      if (hi_a > NA*TD + 1) lows_a = 0;
    end else begin
      if (prev_a) lows_a++;
      hi_a = 0;
    end
    prev_a = (sel_a === 1'b1);
    joy_a  = pad_pins(ta[port_a], ba[port_a], sel_a, lows_a);
  end

  always @(negedge clk) begin
    if (sel_b === 1'b1) begin
      hi_b++;
      if (hi_b > NB*TD + 1) lows_b = 0;
    end else begin
      if (prev_b) lows_b++;
      hi_b = 0;
    end
    prev_b = (sel_b === 1'b1);
    joy_b  = pad_pins(tb4[port_b], bb[port_b], sel_b, lows_b);
  end

  task automatic wait_frame(input int which);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 0) ? fd_a : fd_b) && n < 400);
    checks++;
    if (!((which == 0) ? fd_a : fd_b)) begin
      failures++;
      $display("FAIL wait_frame dut%0d: frame_done=0 after %0d cycles, required 1", which, n);
    end
  endtask

  task automatic apply_a(input int t0, input logic [11:0] b0, input int t1, input logic [11:0] b1);
    wait_frame(0);
    ta[0] = t0; ba[0] = b0; ta[1] = t1; ba[1] = b1;
    wait_frame(0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (js_a !== 24'h0 || js_b !== 48'h0) begin failures++; $display("FAIL reset_joystick: a=%h b=%h required 0", js_a, js_b); end
    checks++; if (md_a !== 2'b0 || six_a !== 2'b0) begin failures++; $display("FAIL reset_pad: md=%b six=%b required 00", md_a, six_a); end
    checks++; if (sel_a !== 1'b1 || port_a !== 1'b0) begin failures++; $display("FAIL reset_sel: sel=%b port=%0d required 1/0", sel_a, port_a); end
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL reset_frame_done: %b required 0", fd_a); end
    reset = 1'b0;
    n = 0;
    while (fd_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    // The release edge is cycle 0, so the last frame cycle is FLEN_A-1.
    checks++; if (n != FLEN_A - 1) begin failures++; $display("FAIL first_frame_done: cycle %0d required %0d", n, FLEN_A - 1); end
    @(negedge clk);
    checks++; if (js_a !== 24'h0 || md_a !== 2'b0 || six_a !== 2'b0) begin
      failures++; $display("FAIL idle_frame: js=%h md=%b six=%b required 0", js_a, md_a, six_a);
    end
  endtask

  task automatic test_three_btn;
    apply_a(MD3, 12'h041, NONE, 12'h0);
    checks++; if (js_a !== 24'h000041) begin failures++; $display("FAIL three_btn_js: %h required 000041", js_a); end
    checks++; if (md_a !== 2'b01 || six_a !== 2'b00) begin failures++; $display("FAIL three_btn_pad: md=%b six=%b required 01/00", md_a, six_a); end
  endtask

  task automatic test_six_btn;
    apply_a(NONE, 12'h0, MD6, 12'h200);
    checks++; if (js_a !== 24'h200000) begin failures++; $display("FAIL six_btn_js: %h required 200000", js_a); end
    checks++; if (md_a !== 2'b10 || six_a !== 2'b10) begin failures++; $display("FAIL six_btn_pad: md=%b six=%b required 10/10", md_a, six_a); end
  endtask

  task automatic test_sms;
    apply_a(SMS, 12'h010, NONE, 12'h0);
    checks++; if (js_a !== 24'h000010) begin failures++; $display("FAIL sms_js: %h required 000010", js_a); end
    checks++; if (md_a !== 2'b00 || six_a !== 2'b00) begin failures++; $display("FAIL sms_pad: md=%b six=%b required 00/00", md_a, six_a); end
  endtask

  task automatic test_select_timing;
    int sel_err, port_err, fd_err, slot;
    logic exp_sel;
    int exp_port;
    sel_err = 0; port_err = 0; fd_err = 0;
    wait_frame(0);
    for (int k = 0; k < FLEN_A; k++) begin
      @(negedge clk);
      slot = k / TD;
      if (slot < 8*NA) begin
        exp_sel  = ((slot / NA) % 2) == 0;
        exp_port = slot % NA;
      end else begin
        exp_sel  = 1'b1;
        exp_port = 0;
      end
      if (sel_a !== exp_sel) begin
        if (sel_err == 0) $display("FAIL sel_seq: cycle %0d sel=%b required %b", k, sel_a, exp_sel);
        sel_err++;
      end
      if (int'(port_a) != exp_port) begin
        if (port_err == 0) $display("FAIL port_seq: cycle %0d port=%0d required %0d", k, port_a, exp_port);
        port_err++;
      end
      if (fd_a !== (k == FLEN_A - 1)) begin
        if (fd_err == 0) $display("FAIL frame_period: cycle %0d frame_done=%b required %b", k, fd_a, (k == FLEN_A - 1));
        fd_err++;
      end
    end
    checks++; if (sel_err != 0) failures++;
    checks++; if (port_err != 0) failures++;
    checks++; if (fd_err != 0) failures++;
  endtask

  task automatic test_random;
    int t0, t1;
    logic [11:0] b0, b1;
    logic [23:0] e;
    for (int it = 0; it < 6; it++) begin
      t0 = $urandom_range(3); t1 = $urandom_range(3);
      b0 = rand_btn(); b1 = rand_btn();
      apply_a(t0, b0, t1, b1);
      e = {exp_slice(t1, b1), exp_slice(t0, b0)};
      checks++; if (js_a !== e) begin failures++; $display("FAIL random_js[%0d]: %h required %h (types %0d,%0d)", it, js_a, e, t0, t1); end
      checks++; if (md_a !== {t1 >= MD3, t0 >= MD3} || six_a !== {t1 == MD6, t0 == MD6}) begin
        failures++; $display("FAIL random_pad[%0d]: md=%b six=%b types %0d,%0d", it, md_a, six_a, t0, t1);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    apply_a(MD3, 12'h0C5, MD6, 12'hFF1);
    wait_frame(0);
    repeat (26) @(negedge clk);
    checks++; if (sel_a !== 1'b0) begin failures++; $display("FAIL midreset_p3_sel: %b required 0", sel_a); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (js_a !== 24'h0 || md_a !== 2'b0 || six_a !== 2'b0) begin
      failures++; $display("FAIL midreset_clear: js=%h md=%b six=%b required 0", js_a, md_a, six_a);
    end
    checks++; if (sel_a !== 1'b1 || port_a !== 1'b0) begin failures++; $display("FAIL midreset_sel: sel=%b port=%0d required 1/0", sel_a, port_a); end
    repeat (10) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (fd_a !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
      if (fd_a !== 1'b1 && js_a !== 24'h0) begin
        checks++; failures++; $display("FAIL midreset_hold: js=%h required 0 at cycle %0d", js_a, n);
      end
    end
    checks++; if (n != FLEN_A - 1) begin failures++; $display("FAIL midreset_frame_done: cycle %0d required %0d", n, FLEN_A - 1); end
    @(negedge clk);
    checks++; if (js_a !== 24'hFF10C5 || md_a !== 2'b11 || six_a !== 2'b10) begin
      failures++; $display("FAIL midreset_recover: js=%h md=%b six=%b required FF10C5/11/10", js_a, md_a, six_a);
    end
  endtask

  task automatic test_four_port;
    logic [47:0] e;
    logic [3:0]  em, es;
    for (int it = 0; it < 3; it++) begin
      wait_frame(1);
      for (int p = 0; p < NB; p++) begin
        tb4[p] = (it == 0) ? (p * 3 + 3) % 4 : int'($urandom_range(3));
        bb[p]  = rand_btn();
      end
      wait_frame(1);
      @(negedge clk);
      for (int p = 0; p < NB; p++) begin
        e[12*p +: 12] = exp_slice(tb4[p], bb[p]);
        em[p] = tb4[p] >= MD3;
        es[p] = tb4[p] == MD6;
      end
      checks++; if (js_b !== e) begin failures++; $display("FAIL four_port_js[%0d]: %h required %h", it, js_b, e); end
      checks++; if (md_b !== em || six_b !== es) begin
        failures++; $display("FAIL four_port_pad[%0d]: md=%b six=%b required %b/%b", it, md_b, six_b, em, es);
      end
    end
  endtask

  initial begin
    joy_a = 6'h3F;
    joy_b = 6'h3F;
    for (int p = 0; p < 4; p++) begin
      ta[p] = NONE; tb4[p] = NONE; ba[p] = 12'h0; bb[p] = 12'h0;
    end
    test_reset;
    test_three_btn;
    test_six_btn;
    test_sms;
    test_select_timing;
    test_random;
    test_reset_mid_frame;
    test_four_port;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
